// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing generator on the pixel clock.
// Produces DrawX/DrawY/blank for the renderers, hs/vs for the monitor, and
// line/frame strobes plus a wrapping frame counter for game logic.
// Optional build macro: VGA_PIPE_ALIGN_EN delays hs/vs by one extra flop so
// sync edges line up with the one-cycle registered RGB of downstream stages.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Counters are 10 bits wide, so the raster must fit in 1024x1024.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
    end

    logic       h_wrap;
    logic [9:0] x_nxt;
    logic [9:0] y_nxt;
    logic       blank_nxt;
    logic       hs_nxt;
    logic       vs_nxt;
    logic       line_start_nxt;
    logic       frame_start_nxt;

    // Next raster position and the outputs that describe it, so every
    // registered output matches the DrawX/DrawY shown in the same cycle.
    always_comb begin
        h_wrap          = (DrawX == H_LAST);
        x_nxt           = h_wrap ? 10'd0 : DrawX + 10'd1;
        y_nxt           = DrawY;
        if (h_wrap) begin
            y_nxt = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
        end
        blank_nxt       = (x_nxt < H_ACT) && (y_nxt < V_ACT);
        hs_nxt          = !((x_nxt >= HS_BEGIN) && (x_nxt < HS_END));
        vs_nxt          = !((y_nxt >= VS_BEGIN) && (y_nxt < VS_END));
        line_start_nxt  = (x_nxt == 10'd0);
        frame_start_nxt = (x_nxt == 10'd0) && (y_nxt == 10'd0);
    end

`ifdef VGA_PIPE_ALIGN_EN
    logic hs_dly;
    logic vs_dly;

    // Extra sync stage: hs/vs trail the pixel position by one cycle.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_dly <= 1'b1;
            vs_dly <= 1'b1;
            hs     <= 1'b1;
            vs     <= 1'b1;
        end else begin
            hs_dly <= hs_nxt;
            vs_dly <= vs_nxt;
            hs     <= hs_dly;
            vs     <= vs_dly;
        end
    end
`else
    // Sync outputs aligned with the pixel position.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs <= 1'b1;
            vs <= 1'b1;
        end else begin
            hs <= hs_nxt;
            vs <= vs_nxt;
        end
    end
`endif

    // Raster position, blanking, strobes and frame counter. Reset parks the
    // counters on the last pixel so the first edge after release lands on (0,0).
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= H_LAST;
            DrawY       <= V_LAST;
            blank       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            DrawX       <= x_nxt;
            DrawY       <= y_nxt;
            blank       <= blank_nxt;
            line_start  <= line_start_nxt;
            frame_start <= frame_start_nxt;
            if (frame_start_nxt) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: full-size instance for reset and line timing,
// reduced-raster instance (8x7) for frame, vsync, counter wrap and mid-frame reset.
module tb_vga_timing_gen;

`ifdef VGA_PIPE_ALIGN_EN
    localparam logic P = 1'b1;
`else
    localparam logic P = 1'b0;
`endif

    logic       vga_clk = 1'b0;
    logic       rst_a, rst_b;
    logic [9:0] dx_a, dy_a, dx_b, dy_b;
    logic       blank_a, hs_a, vs_a, ls_a, fs_a;
    logic       blank_b, hs_b, vs_b, ls_b, fs_b;
    logic [7:0] fc_a, fc_b;

    int checks   = 0;
    int failures = 0;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen u_dut (
        .vga_clk(vga_clk), .reset_n(rst_a), .DrawX(dx_a), .DrawY(dy_a),
        .blank(blank_a), .hs(hs_a), .vs(vs_a), .line_start(ls_a),
        .frame_start(fs_a), .frame_count(fc_a)
    );

    // Small raster: H 4+1+2+1=8 (hs low x 5..6), V 3+1+2+1=7 (vs low y 4..5).
    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_small (
        .vga_clk(vga_clk), .reset_n(rst_b), .DrawX(dx_b), .DrawY(dy_b),
        .blank(blank_b), .hs(hs_b), .vs(vs_b), .line_start(ls_b),
        .frame_start(fs_b), .frame_count(fc_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int   cyc;
        int   x;
        int   y;
        logic blank;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
        int   fc;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int cur;
        int hs_lo, bl_hi, ls_n, first_lo;
        int k, ex, ey, fc_e;
        logic hs_def, vs_def, hs_e, vs_e, prev_hs, prev_vs;

        vecs[0]  = '{1,   0,   0, 1, 1, 1, 1, 1, 1};
        vecs[1]  = '{2,   1,   0, 1, 1, 1, 0, 0, 1};
        vecs[2]  = '{640, 639, 0, 1, 1, 1, 0, 0, 1};
        vecs[3]  = '{641, 640, 0, 0, 1, 1, 0, 0, 1};
        vecs[4]  = '{656, 655, 0, 0, 1, 1, 0, 0, 1};
        vecs[5]  = '{657, 656, 0, 0, P, 1, 0, 0, 1};
        vecs[6]  = '{658, 657, 0, 0, 0, 1, 0, 0, 1};
        vecs[7]  = '{752, 751, 0, 0, 0, 1, 0, 0, 1};
        vecs[8]  = '{753, 752, 0, 0, ~P, 1, 0, 0, 1};
        vecs[9]  = '{754, 753, 0, 0, 1, 1, 0, 0, 1};
        vecs[10] = '{800, 799, 0, 0, 1, 1, 0, 0, 1};
        vecs[11] = '{801, 0,   1, 1, 1, 1, 1, 0, 1};
        vecs[12] = '{802, 1,   1, 1, 1, 1, 0, 0, 1};

        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (5) @(negedge vga_clk);

        chk("rst_x", dx_a, 799);
        chk("rst_y", dy_a, 524);
        chk("rst_blank", blank_a, 0);
        chk("rst_hs", hs_a, 1);
        chk("rst_vs", vs_a, 1);
        chk("rst_ls", ls_a, 0);
        chk("rst_fs", fs_a, 0);
        chk("rst_fc", fc_a, 0);

        rst_a = 1'b1;
        cur = 0;
        foreach (vecs[i]) begin
            repeat (vecs[i].cyc - cur) @(negedge vga_clk);
            cur = vecs[i].cyc;
            chk($sformatf("v%0d_x", i), dx_a, vecs[i].x);
            chk($sformatf("v%0d_y", i), dy_a, vecs[i].y);
            chk($sformatf("v%0d_blank", i), blank_a, vecs[i].blank);
            chk($sformatf("v%0d_hs", i), hs_a, vecs[i].hs);
            chk($sformatf("v%0d_vs", i), vs_a, vecs[i].vs);
            chk($sformatf("v%0d_ls", i), ls_a, vecs[i].ls);
            chk($sformatf("v%0d_fs", i), fs_a, vecs[i].fs);
            chk($sformatf("v%0d_fc", i), fc_a, vecs[i].fc);
        end

        // Full line sweep: x=2..799 of line 1, then x=0,1 of line 2.
        hs_lo = 0; bl_hi = 0; ls_n = 0; first_lo = -1;
        repeat (800) begin
            @(negedge vga_clk);
            if (!hs_a) begin
                hs_lo++;
                if (first_lo < 0) first_lo = dx_a;
            end
            if (blank_a) bl_hi++;
            if (ls_a) begin
                ls_n++;
                chk("line_start_y", dy_a, 2);
            end
        end
        chk("line_hs_low_count", hs_lo, 96);
        chk("line_hs_first_x", first_lo, P ? 657 : 656);
        chk("line_blank_count", bl_hi, 640);
        chk("line_start_count", ls_n, 1);

        // Small raster: 257 frames against a cycle-index model.
        rst_b = 1'b1;
        prev_hs = 1'b1; prev_vs = 1'b1;
        for (int n = 1; n <= 257 * 56 + 3; n++) begin
            @(negedge vga_clk);
            k  = n - 1;
            ex = k % 8;
            ey = (k / 8) % 7;
            fc_e = (k / 56 + 1) % 256;
            hs_def = !((ex >= 5) && (ex < 7));
            vs_def = !((ey >= 4) && (ey < 6));
            hs_e = P ? ((k == 0) ? 1'b1 : prev_hs) : hs_def;
            vs_e = P ? ((k == 0) ? 1'b1 : prev_vs) : vs_def;
            prev_hs = hs_def;
            prev_vs = vs_def;
            chk("s_x", dx_b, ex);
            chk("s_y", dy_b, ey);
            chk("s_blank", blank_b, (ex < 4) && (ey < 3));
            chk("s_hs", hs_b, hs_e);
            chk("s_vs", vs_b, vs_e);
            chk("s_ls", ls_b, ex == 0);
            chk("s_fs", fs_b, (ex == 0) && (ey == 0));
            chk("s_fc", fc_b, fc_e);
            if (k == 255 * 56) chk("fc_wrap_to_0", fc_b, 0);
            if (k == 256 * 56) chk("fc_after_wrap", fc_b, 1);
        end

        // Move to (2,1) and pull reset between edges.
        repeat (8) @(negedge vga_clk);
        chk("mid_pre_x", dx_b, 2);
        chk("mid_pre_y", dy_b, 1);
        #2 rst_b = 1'b0;
        #1;
        chk("mid_rst_x", dx_b, 7);
        chk("mid_rst_y", dy_b, 6);
        chk("mid_rst_blank", blank_b, 0);
        chk("mid_rst_hs", hs_b, 1);
        chk("mid_rst_vs", vs_b, 1);
        chk("mid_rst_ls", ls_b, 0);
        chk("mid_rst_fs", fs_b, 0);
        chk("mid_rst_fc", fc_b, 0);
        repeat (2) @(negedge vga_clk);
        rst_b = 1'b1;
        @(negedge vga_clk);
        chk("restart_x", dx_b, 0);
        chk("restart_y", dy_b, 0);
        chk("restart_blank", blank_b, 1);
        chk("restart_ls", ls_b, 1);
        chk("restart_fs", fs_b, 1);
        chk("restart_fc", fc_b, 1);
        @(negedge vga_clk);
        chk("restart2_x", dx_b, 1);
        chk("restart2_fs", fs_b, 0);
        chk("restart2_fc", fc_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Free-running VGA raster timing generator clocked by the pixel clock.
- Drives DrawX, DrawY and blank into the downstream sprite and background renderers, and drives hs and vs to the monitor.
- Produces frame and line strobes plus a frame counter for game-logic sequencing.
- Sits directly upstream of every pixel-drawing stage.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines
- Derived, not overridable: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤ 1024.

Ports:
- vga_clk  in  1  pixel clock; all state updates on its posedge
- reset_n  in  1  asynchronous active-low reset
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1
- DrawY  out  10  current vertical count, 0..V_TOTAL-1
- blank  out  1  1 = active video (pixel may be drawn), 0 = blanking
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- line_start  out  1  one-cycle pulse while DrawX==0
- frame_start  out  1  one-cycle pulse while DrawX==0 and DrawY==0
- frame_count  out  8  frames started since reset, wraps

Behaviour:
- Every output is a flop. No combinational path from any input to any output.
- Reset (reset_n=0, asynchronous) sets:
  - DrawX=H_TOTAL-1 (799), DrawY=V_TOTAL-1 (524)
  - blank=0, hs=1, vs=1
  - line_start=0, frame_start=0, frame_count=0
- First posedge after reset release wraps to (0,0), asserts frame_start and line_start, and sets frame_count=1.
- Horizontal count: DrawX increments by 1 each posedge. At H_TOTAL-1 it wraps to 0 and DrawY advances.
- Vertical count: DrawY increments only on a horizontal wrap. At V_TOTAL-1 with a horizontal wrap, DrawY wraps to 0.
- Registered outputs are computed from the next-state counter values, so within any cycle blank, hs, vs and the strobes describe the DrawX/DrawY shown in that same cycle.
- blank = (DrawX < H_ACTIVE) && (DrawY < V_ACTIVE).
- hs = 0 iff H_ACTIVE+H_FP ≤ DrawX < H_ACTIVE+H_FP+H_SYNC (656..751).
- vs = 0 iff V_ACTIVE+V_FP ≤ DrawY < V_ACTIVE+V_FP+V_SYNC (490..491). vs changes only on line boundaries, together with DrawX=0.
- frame_count increments in the same cycle frame_start is asserted; 255 wraps to 0.
- Comparisons use 10-bit unsigned arithmetic; no intermediate may exceed 10 bits.
- Mid-frame reset: outputs go to their reset values immediately (asynchronous). The frame restarts at (0,0) on the first posedge after release. No partial-state carry-over.
- The frame period is H_TOTAL*V_TOTAL = 420000 cycles exactly, with no drift.

Optional Feature:
- Macro: VGA_PIPE_ALIGN_EN.
- Defined:
  - hs and vs each pass through one extra flop stage, so they lag DrawX/DrawY/blank by 1 cycle.
  - This compensates the one-cycle registered RGB latency of downstream renderers, so sync edges align with pixel colour at the connector.
  - Extra stage resets to 1.
  - Sync values in the first cycle after reset release are 1.
- Undefined: hs and vs are aligned with DrawX exactly as specified in Behaviour.
- DrawX, DrawY, blank, the strobes and frame_count are identical in both builds.

Test Plan:
- Reset: hold reset_n=0 for 5 cycles → DrawX=799, DrawY=524, blank=0, hs=1, vs=1, frame_count=0. Release → next posedge gives DrawX=0, DrawY=0, blank=1, frame_start=1, line_start=1, frame_count=1.
- Line timing: run 800 cycles from (0,0) →
  - blank=1 for DrawX 0..639, 0 for 640..799
  - hs=0 exactly for DrawX 656..751 (96 cycles)
  - line_start pulses at cycle 800, with DrawY=1
- Frame timing: run 420000 cycles →
  - vs=0 exactly while DrawY is 490..491 (1600 cycles)
  - blank=0 for all of DrawY 480..524
  - next frame_start at cycle 420000; frame_count=2
- Counter wrap: run 256 frames → frame_count goes 255→0 on the 256th frame_start, and 1 on the 257th. Verify by forcing the check at frame boundaries.
- Mid-frame reset: assert reset_n=0 asynchronously at DrawX=300, DrawY=200 between clock edges → outputs take reset values before the next posedge. After release, the sequence restarts at (0,0) with frame_count=1.
- VGA_PIPE_ALIGN_EN build: hs falls at the posedge where DrawX=657 (not 656), vs falls at DrawX=1 of line 490. All other outputs are bit-identical to the default build.
